// File: rtl/panel_led_ctrl_if.sv
// Register-slave bus bundle for panel_led_ctrl.
//   avs_ctrl_address   : word address (3 bits)
//   avs_ctrl_write     : write strobe, zero wait states
//   avs_ctrl_writedata : write data
//   avs_ctrl_read      : read strobe
//   avs_ctrl_readdata  : registered read data, valid one cycle after the strobe
// Modports: master (bus driver / testbench side), slave (panel_led_ctrl side).
interface panel_led_ctrl_if;
    logic [2:0]  avs_ctrl_address;
    logic        avs_ctrl_write;
    logic [31:0] avs_ctrl_writedata;
    logic        avs_ctrl_read;
    logic [31:0] avs_ctrl_readdata;

    modport master (
        output avs_ctrl_address,
        output avs_ctrl_write,
        output avs_ctrl_writedata,
        output avs_ctrl_read,
        input  avs_ctrl_readdata
    );

    modport slave (
        input  avs_ctrl_address,
        input  avs_ctrl_write,
        input  avs_ctrl_writedata,
        input  avs_ctrl_read,
        output avs_ctrl_readdata
    );
endinterface

// File: rtl/panel_led_ctrl.sv
// RGB panel LED PWM controller with a small register slave.
//
// Ports:
//   csi_MCLK_clk      : clock, all state on the rising edge
//   rsi_MRST_reset    : asynchronous active-high reset
//   avs               : register slave (panel_led_ctrl_if.slave)
//   coe_led_r/g/b     : registered active-high PWM drive, one bit per LED
//   coe_frame         : one-cycle pulse when the PWM counter wraps to 0
//
// Register map (word addresses):
//   0 CTRL  : [0] enable, [31:16] prescaler P
//   1..4 LEDn: [7:0] R, [15:8] G, [23:16] B duty, [25:24] mode (0 off, 1 on, 2 blink, 3 off)
//   5 BLINK : [15:0] half-period H in frames (only with PANEL_LED_BLINK_EN)
//   others read 0, writes ignored.
//
// Configuration macro: PANEL_LED_BLINK_EN enables the BLINK register, the blink
// frame counter and blink mode 2. Without it mode 2 behaves as mode 1.
// PRESC_W is expected to be at most 16 (the width of the CTRL prescaler field).
module panel_led_ctrl #(
    parameter int unsigned NUM_LED = 4,
    parameter int unsigned PRESC_W = 16
) (
    input  logic               csi_MCLK_clk,
    input  logic               rsi_MRST_reset,
    panel_led_ctrl_if.slave    avs,
    output logic [NUM_LED-1:0] coe_led_r,
    output logic [NUM_LED-1:0] coe_led_g,
    output logic [NUM_LED-1:0] coe_led_b,
    output logic               coe_frame
);

    // Register file and shadows.
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [25:0]        led_reg_q [NUM_LED];
    logic [25:0]        led_reg_d [NUM_LED];
    logic [25:0]        shadow_q [NUM_LED];
    logic [25:0]        shadow_d [NUM_LED];

    // Counters and outputs.
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [7:0]         pwm_q, pwm_d;
    logic [NUM_LED-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               frame_q, frame_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        rd_word;
    logic               tick, wrap, run, blink_on;

`ifdef PANEL_LED_BLINK_EN
    logic [15:0] blink_h_q, blink_h_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    assign blink_on = phase_q;
`else
    assign blink_on = 1'b1;
`endif

    // Only some writedata bits are stored; the rest are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^avs.avs_ctrl_writedata;

    always_comb begin
        en_d        = en_q;
        presc_d     = presc_q;
        led_reg_d   = led_reg_q;
        shadow_d    = shadow_q;
        presc_cnt_d = presc_cnt_q;
        pwm_d       = pwm_q;
        rdata_d     = rdata_q;
        rd_word     = '0;
`ifdef PANEL_LED_BLINK_EN
        blink_h_d   = blink_h_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
`endif

        // Register writes.
        if (avs.avs_ctrl_write) begin
            if (avs.avs_ctrl_address == 3'd0) begin
                en_d    = avs.avs_ctrl_writedata[0];
                presc_d = avs.avs_ctrl_writedata[16 +: PRESC_W];
            end
`ifdef PANEL_LED_BLINK_EN
            if (avs.avs_ctrl_address == 3'd5) begin
                blink_h_d = avs.avs_ctrl_writedata[15:0];
            end
`endif
            for (int i = 0; i < NUM_LED; i++) begin
                if (avs.avs_ctrl_address == 3'(i + 1)) begin
                    led_reg_d[i] = avs.avs_ctrl_writedata[25:0];
                end
            end
        end

        // Read mux samples the pre-write values, so a same-cycle write reads old data.
        if (avs.avs_ctrl_address == 3'd0) begin
            rd_word[0]              = en_q;
            rd_word[16 +: PRESC_W]  = presc_q;
        end
`ifdef PANEL_LED_BLINK_EN
        if (avs.avs_ctrl_address == 3'd5) begin
            rd_word[15:0] = blink_h_q;
        end
`endif
        for (int i = 0; i < NUM_LED; i++) begin
            if (avs.avs_ctrl_address == 3'(i + 1)) begin
                rd_word[25:0] = led_reg_q[i];
            end
        end
        if (avs.avs_ctrl_read) begin
            rdata_d = rd_word;
        end

        // Live compare against P: a P lowered below the current count lets the
        // counter run on and wrap through its maximum value.
        tick = en_q && (presc_cnt_q == presc_q);
        wrap = tick && (pwm_q == 8'hFF);
        run  = en_q && en_d;

        if (!en_d) begin
            presc_cnt_d = '0;
            pwm_d       = '0;
`ifdef PANEL_LED_BLINK_EN
            blink_cnt_d = '0;
            phase_d     = 1'b0;
`endif
        end else if (!en_q) begin
            // Enable rising: fresh frame, shadows loaded now, blink starts active.
            presc_cnt_d = '0;
            pwm_d       = '0;
            shadow_d    = led_reg_q;
`ifdef PANEL_LED_BLINK_EN
            blink_cnt_d = '0;
            phase_d     = 1'b1;
`endif
        end else begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
            if (tick) begin
                pwm_d = pwm_q + 8'd1;
            end
            if (wrap) begin
                shadow_d = led_reg_q;
`ifdef PANEL_LED_BLINK_EN
                if (blink_cnt_q == blink_h_q) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 16'd1;
                end
`endif
            end
        end

        // Outputs are registered from the current counter and shadow state.
        for (int i = 0; i < NUM_LED; i++) begin
            r_d[i] = run && ((shadow_q[i][25:24] == 2'd1) ||
                             ((shadow_q[i][25:24] == 2'd2) && blink_on)) &&
                     (pwm_q < shadow_q[i][7:0]);
            g_d[i] = run && ((shadow_q[i][25:24] == 2'd1) ||
                             ((shadow_q[i][25:24] == 2'd2) && blink_on)) &&
                     (pwm_q < shadow_q[i][15:8]);
            b_d[i] = run && ((shadow_q[i][25:24] == 2'd1) ||
                             ((shadow_q[i][25:24] == 2'd2) && blink_on)) &&
                     (pwm_q < shadow_q[i][23:16]);
        end
        frame_d = run && wrap;
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            en_q        <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pwm_q       <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            frame_q     <= 1'b0;
            rdata_q     <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                led_reg_q[i] <= '0;
                shadow_q[i]  <= '0;
            end
`ifdef PANEL_LED_BLINK_EN
            blink_h_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
`endif
        end else begin
            en_q        <= en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_q       <= pwm_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            frame_q     <= frame_d;
            rdata_q     <= rdata_d;
            for (int i = 0; i < NUM_LED; i++) begin
                led_reg_q[i] <= led_reg_d[i];
                shadow_q[i]  <= shadow_d[i];
            end
`ifdef PANEL_LED_BLINK_EN
            blink_h_q   <= blink_h_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
`endif
        end
    end

    assign avs.avs_ctrl_readdata = rdata_q;
    assign coe_led_r             = r_q;
    assign coe_led_g             = g_q;
    assign coe_led_b             = b_q;
    assign coe_frame             = frame_q;

endmodule

// File: tb/tb_panel_led_ctrl.sv
// Self-checking bench for panel_led_ctrl: register table, directed PWM/blink/reset
// sequences and randomized configurations against a cycle-position model.
module tb_panel_led_ctrl;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] led_r, led_g, led_b;
    logic          frame;

    panel_led_ctrl_if bus ();

    panel_led_ctrl #(.NUM_LED(NL), .PRESC_W(16)) dut (
        .csi_MCLK_clk  (clk),
        .rsi_MRST_reset(rst),
        .avs           (bus.slave),
        .coe_led_r     (led_r),
        .coe_led_g     (led_g),
        .coe_led_b     (led_b),
        .coe_frame     (frame)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model configuration: prescaler, blink half-period and LED register words.
    int          m_p;
    int          m_h;
    logic [31:0] m_led [NL];
    logic [12:0] hist [$];   // {frame, b, g, r} per sample index since enable

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;
    reg_vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.avs_ctrl_address   = a;
        bus.avs_ctrl_writedata = d;
        bus.avs_ctrl_write     = 1'b1;
        step();
        bus.avs_ctrl_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.avs_ctrl_address = a;
        bus.avs_ctrl_read    = 1'b1;
        step();
        bus.avs_ctrl_read    = 1'b0;
        d = bus.avs_ctrl_readdata;
    endtask

    // Expected outputs s cycles after the enabling write took effect. A tick lasts
    // P+1 cycles, a frame 256 ticks; LED outputs lag the counter state by one cycle.
    function automatic logic [12:0] model(input int s);
        logic [3:0] r, g, b;
        logic       fr, act;
        logic [1:0] mode;
        int         t, pwm, f;
        r  = '0;
        g  = '0;
        b  = '0;
        fr = (s > 0) && (s % (256 * (m_p + 1)) == 0);
        if (s >= 1) begin
            t   = (s - 1) / (m_p + 1);
            pwm = t % 256;
            f   = t / 256;
            for (int i = 0; i < NL; i++) begin
                mode = m_led[i][25:24];
`ifdef PANEL_LED_BLINK_EN
                act = (mode == 2'd1) || ((mode == 2'd2) && (((f / (m_h + 1)) % 2) == 0));
`else
                act = (mode == 2'd1) || (mode == 2'd2) || (f < 0);
`endif
                r[i] = act && (pwm < int'(m_led[i][7:0]));
                g[i] = act && (pwm < int'(m_led[i][15:8]));
                b[i] = act && (pwm < int'(m_led[i][23:16]));
            end
        end
        return {fr, b, g, r};
    endfunction

    // Disable, load the model configuration, then enable.
    task automatic start();
        wr(3'd0, 32'd0);
        for (int i = 0; i < NL; i++) wr(3'(i + 1), m_led[i]);
`ifdef PANEL_LED_BLINK_EN
        wr(3'd5, 32'(m_h));
`endif
        wr(3'd0, {m_p[15:0], 15'd0, 1'b1});
    endtask

    // Run n cycles recording outputs; optionally compare with the model and
    // optionally issue one register write at sample index ws.
    task automatic run(input int n, input bit cmp, input int ws, input logic [2:0] wa,
                       input logic [31:0] wd, input string name);
        logic [12:0] v;
        hist.delete();
        for (int s = 0; s < n; s++) begin
            v = {frame, led_b, led_g, led_r};
            hist.push_back(v);
            if (cmp) check(name, 32'(v), 32'(model(s)));
            if (s == ws) begin
                bus.avs_ctrl_address   = wa;
                bus.avs_ctrl_writedata = wd;
                bus.avs_ctrl_write     = 1'b1;
            end
            step();
            bus.avs_ctrl_write = 1'b0;
        end
    endtask

    function automatic int cnt(input int bitpos, input int s0, input int len);
        int c = 0;
        for (int s = s0; s < s0 + len; s++) c += int'(hist[s][bitpos]);
        return c;
    endfunction

    initial begin
        logic [31:0] d;
        int          expn;

        tbl[0] = '{3'd1, 32'h0102_0304, 32'h0102_0304};
        tbl[1] = '{3'd2, 32'hFFFF_FFFF, 32'h03FF_FFFF};
        tbl[2] = '{3'd3, 32'h1234_5678, 32'h0234_5678};
        tbl[3] = '{3'd4, 32'h00AA_55CC, 32'h00AA_55CC};
`ifdef PANEL_LED_BLINK_EN
        tbl[4] = '{3'd5, 32'hFFFF_1234, 32'h0000_1234};
`else
        tbl[4] = '{3'd5, 32'hFFFF_1234, 32'h0000_0000};
`endif
        tbl[5] = '{3'd6, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[6] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7] = '{3'd0, 32'hABCD_0000, 32'hABCD_0000};

        bus.avs_ctrl_address   = '0;
        bus.avs_ctrl_write     = 1'b0;
        bus.avs_ctrl_writedata = '0;
        bus.avs_ctrl_read      = 1'b0;
        rst = 1'b1;

        // Reset state.
        #1;
        check("reset_outputs", 32'({frame, led_b, led_g, led_r}), 32'd0);
        check("reset_rdata", bus.avs_ctrl_readdata, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check("reset_readback", d, 32'd0);
        end

        // Register table: write all, then read all back.
        for (int i = 0; i < 8; i++) wr(tbl[i].addr, tbl[i].wdata);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].addr, d);
            check($sformatf("reg_tbl_a%0d", tbl[i].addr), d, tbl[i].exp);
        end

        // Read latency 1 and hold.
        rd(3'd1, d);
        check("rd_addr1", d, 32'h0102_0304);
        for (int i = 0; i < 5; i++) step();
        check("rdata_hold", bus.avs_ctrl_readdata, 32'h0102_0304);
        rd(3'd7, d);
        check("rd_addr7", d, 32'd0);

        // Same-address read and write returns the old value.
        wr(3'd3, 32'h0000_00AA);
        bus.avs_ctrl_address   = 3'd3;
        bus.avs_ctrl_writedata = 32'h0000_0055;
        bus.avs_ctrl_write     = 1'b1;
        bus.avs_ctrl_read      = 1'b1;
        step();
        bus.avs_ctrl_write = 1'b0;
        bus.avs_ctrl_read  = 1'b0;
        check("rw_same_old", bus.avs_ctrl_readdata, 32'h0000_00AA);
        rd(3'd3, d);
        check("rw_same_new", d, 32'h0000_0055);

        // P=0, LED0 R duty 64 mode 1.
        m_p = 0;
        m_h = 0;
        m_led[0] = 32'h0100_0040;
        m_led[1] = 32'd0;
        m_led[2] = 32'd0;
        m_led[3] = 32'd0;
        start();
        run(600, 1'b1, -1, 3'd0, 32'd0, "p0_r64");
        check("p0_r64_frame0", 32'(cnt(0, 1, 256)), 32'd64);
        check("p0_r64_frame1", 32'(cnt(0, 257, 256)), 32'd64);
        check("p0_frame_count", 32'(cnt(12, 1, 512)), 32'd2);
        check("p0_frame_at256", 32'(hist[256][12]), 32'd1);

        // P=3, LED2 B duty 255, LED1 B duty 0.
        m_p = 3;
        m_led[0] = 32'd0;
        m_led[1] = 32'h0100_0000;
        m_led[2] = 32'h01FF_0000;
        start();
        run(2100, 1'b1, -1, 3'd0, 32'd0, "p3_b255");
        check("p3_b255_low", 32'(1024 - cnt(10, 1, 1024)), 32'd4);
        check("p3_b0_high", 32'(cnt(9, 1, 2048)), 32'd0);

        // G duty 32 -> 200 mid-frame takes effect next frame.
        m_p = 0;
        m_led[1] = 32'h0100_2000;
        m_led[2] = 32'd0;
        start();
        run(520, 1'b0, 100, 3'd2, 32'h0100_C800, "g_change");
        check("g_change_cur", 32'(cnt(5, 1, 256)), 32'd32);
        check("g_change_next", 32'(cnt(5, 257, 256)), 32'd200);

        // Blink H=2, mode 2, duty 128 (mode 2 is plain on without blink support).
        m_h = 2;
        m_led[1] = 32'd0;
        m_led[3] = 32'h0200_0080;
        start();
        run(256 * 7 + 4, 1'b1, -1, 3'd0, 32'd0, "blink");
        for (int j = 0; j < 7; j++) begin
`ifdef PANEL_LED_BLINK_EN
            expn = (((j / 3) % 2) == 0) ? 128 : 0;
`else
            expn = 128;
`endif
            check($sformatf("blink_frame%0d", j), 32'(cnt(3, 256 * j + 1, 256)), 32'(expn));
        end

        // Randomized configurations against the model.
        for (int n = 0; n < 6; n++) begin
            m_p = int'($urandom_range(0, 1));
            m_h = int'($urandom_range(0, 2));
            for (int i = 0; i < NL; i++) begin
                logic [7:0] dr, dg, db;
                dr = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                dg = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom);
                db = 8'($urandom);
                m_led[i] = {6'd0, 2'($urandom_range(0, 3)), db, dg, dr};
            end
            start();
            run(2200, 1'b1, -1, 3'd0, 32'd0, $sformatf("rand%0d", n));
        end

        // Asynchronous reset mid-frame with an output high.
        m_p = 0;
        m_h = 0;
        m_led[0] = 32'h0100_00FF;
        m_led[1] = 32'd0;
        m_led[2] = 32'd0;
        m_led[3] = 32'd0;
        start();
        for (int i = 0; i < 10; i++) step();
        check("pre_reset_r0", 32'(led_r[0]), 32'd1);
        rd(3'd0, d);
        check("pre_reset_ctrl", d, 32'h0000_0001);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({frame, led_b, led_g, led_r}), 32'd0);
        check("async_reset_rdata", bus.avs_ctrl_readdata, 32'd0);
        step();
        rst = 1'b0;
        run(40, 1'b0, -1, 3'd0, 32'd0, "post_reset");
        expn = 0;
        for (int s = 0; s < 40; s++) expn += int'(hist[s] != 13'd0);
        check("post_reset_idle", 32'(expn), 32'd0);
        rd(3'd0, d);
        check("post_reset_ctrl", d, 32'd0);
        rd(3'd1, d);
        check("post_reset_led0", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/panel_led_ctrl.md
PANEL_LED_CTRL -- requirements
Module: panel_led_ctrl

Interface
REQ-001 SHALL have parameter NUM_LED, default 4, meaning number of RGB LEDs driven (supported range 1..4).
REQ-002 SHALL have parameter PRESC_W, default 16, meaning width of the PWM tick prescaler.
REQ-003 SHALL have port csi_MCLK_clk  input  1  the single clock of the block; all state is on its rising edge.
REQ-004 SHALL have port rsi_MRST_reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port avs_ctrl_address  input  3  word address of the register slave.
REQ-006 SHALL have port avs_ctrl_write  input  1  write strobe.
REQ-007 SHALL have port avs_ctrl_writedata  input  32  write data.
REQ-008 SHALL have port avs_ctrl_read  input  1  read strobe.
REQ-009 SHALL have port avs_ctrl_readdata  output  32  read data, registered.
REQ-010 SHALL have ports coe_led_r, coe_led_g and coe_led_b  output  NUM_LED each  active-high PWM drive, one bit per LED.
REQ-011 SHALL have port coe_frame  output  1  one-cycle pulse at each PWM frame boundary.

Function
REQ-012 SHALL implement this register map:
- Address 0, CTRL: [0] enable, [31:16] prescaler P.
- Addresses 1..4, LEDn (n = address - 1): [7:0] R duty, [15:8] G duty, [23:16] B duty, [25:24] mode (0 off, 1 on, 2 blink, 3 treated as off).
- Address 5, BLINK: [15:0] half-period H, counted in frames.
- Other addresses: read 0, writes ignored.
REQ-013 SHALL apply a write on the cycle avs_ctrl_write is high, with zero wait states.
REQ-014 SHALL return read data on avs_ctrl_readdata exactly one cycle after avs_ctrl_read (read latency 1), and hold it until the next read.
REQ-015 SHALL, when a read and a write hit the same address in the same cycle, return the old value.
REQ-016 SHALL generate the PWM tick from a prescaler counter:
- Counts 0..P, tick when the count equals P.
- P = 0 gives a tick every cycle.
REQ-017 SHALL advance an 8-bit PWM counter by 1 on each tick, wrapping 255 to 0; the wrap tick is the frame boundary.
REQ-018 SHALL pulse coe_frame for one cycle on the cycle the PWM counter wraps to 0.
REQ-019 SHALL copy the duty and mode registers into shadow registers only at a frame boundary, so output changes never occur mid-frame.
REQ-020 SHALL drive each colour output high when its channel is active and the PWM counter is below the shadow duty:
- duty 0: output always low.
- duty 255: output high 255 of 256 ticks.
REQ-021 SHALL define a channel as active when:
- mode is 1, or
- mode is 2 and the blink phase is 1.
REQ-022 SHALL implement the blink phase as a frame counter 0..H that toggles the phase when it reaches H and then restarts at 0; with H = 0 the phase toggles every frame.
REQ-023 SHALL, while enable is 0:
- hold the prescaler, PWM counter, blink counter and blink phase at 0;
- hold all colour outputs and coe_frame low;
- keep the register slave fully functional.
REQ-024 SHALL, on enable going 0 to 1, load the shadow registers immediately and start the frame at PWM count 0 with blink phase 1.
REQ-025 SHALL register all colour outputs, giving 1 cycle from the counter change to the output change.
REQ-026 SHALL make a write to P take effect from the next prescaler restart; if the current count already exceeds the new P, the counter SHALL wrap at its maximum value.

Reset
REQ-027 SHALL, on rsi_MRST_reset high and regardless of clock, clear to 0 all registers, shadows, counters and the blink phase.
REQ-028 SHALL drive avs_ctrl_readdata, coe_led_r, coe_led_g, coe_led_b and coe_frame to 0 during reset.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame with no residual output pulse, and resume only after enable is written again.

Configuration
REQ-030 SHALL, when macro PANEL_LED_BLINK_EN is defined, include the BLINK register, the blink counter and mode 2 exactly as specified above.
REQ-031 SHALL, when PANEL_LED_BLINK_EN is undefined:
- omit the blink logic;
- treat mode 2 as mode 1;
- read address 5 as 0 and ignore writes to it.

Verification
REQ-032 SHALL cover: P=0, LED0 R duty 64, mode 1, enable -> coe_led_r[0] high for 64 of every 256 cycles, coe_frame period 256 cycles.
REQ-033 SHALL cover: P=3, LED2 B duty 255 -> coe_led_b[2] low exactly 4 cycles per 1024-cycle frame; duty 0 -> constantly low.
REQ-034 SHALL cover: G duty changed from 32 to 200 mid-frame -> current frame still ends G high after 32 ticks, and the next frame shows 200.
REQ-035 SHALL cover: PANEL_LED_BLINK_EN defined, H=2, mode 2, duty 128 -> output toggles between active and inactive every 3 frames.
REQ-036 SHALL cover: reset asserted asynchronously mid-frame with outputs high -> all outputs 0 without a clock edge, and register readback after reset is 0.
REQ-037 SHALL cover: read address 1 after writing 0x0102_0304 -> readdata 0x0102_0304 one cycle after the read strobe; address 7 reads 0.
